// File: rtl/dmem_responder_pkg.sv
// Shared memory map for the data-memory responder: MMIO base, register
// offsets, STATUS bit positions, address decode and STATUS packing helpers.
package dmem_responder_pkg;

  localparam logic [15:0] MMIO_BASE  = 16'hFFFF;
  localparam logic [15:0] OFF_TXDATA = 16'h0000;
  localparam logic [15:0] OFF_STATUS = 16'h0004;
  localparam logic [15:0] OFF_CYCLES = 16'h0008;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_MSB = 15;

  typedef enum logic [2:0] {
    SEL_RAM      = 3'd0,
    SEL_TXDATA   = 3'd1,
    SEL_STATUS   = 3'd2,
    SEL_CYCLES   = 3'd3,
    SEL_UNMAPPED = 3'd4
  } sel_e;

  // Upper half 0xFFFF selects the MMIO page; everything else is RAM.
  function automatic sel_e decode_addr(input logic [31:0] addr);
    sel_e sel;
    if (addr[31:16] == MMIO_BASE) begin
      case (addr[15:0])
        OFF_TXDATA: sel = SEL_TXDATA;
        OFF_STATUS: sel = SEL_STATUS;
        OFF_CYCLES: sel = SEL_CYCLES;
        default:    sel = SEL_UNMAPPED;
      endcase
    end else begin
      sel = SEL_RAM;
    end
    return sel;
  endfunction

  function automatic logic [31:0] pack_status(input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [7:0] count);
    logic [31:0] s;
    s = 32'h0000_0000;
    s[STAT_FULL_BIT]  = full;
    s[STAT_EMPTY_BIT] = empty;
    s[STAT_OVF_BIT]   = ovf;
    s[STAT_COUNT_MSB:STAT_COUNT_LSB] = count;
    return s;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Processor data-memory bus plus console transmit handshake.
interface dmem_responder_if;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport slave (
    input  address_dmem, data, wren, tx_ready,
    output q_dmem, tx_data, tx_valid
  );

  modport master (
    output address_dmem, data, wren, tx_ready,
    input  q_dmem, tx_data, tx_valid
  );
endinterface

// File: rtl/dmem_responder_sync_fifo.sv
// Synchronous FIFO with occupancy count and a sticky overflow flag.
// A push into a full FIFO is accepted only if a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clr_ovf,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             overflow_r;
  logic             pop_ok_s;
  logic             push_ok_s;
  logic             ovf_set_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign overflow  = overflow_r;
  // Gate with empty so the head reads zero whenever nothing is queued.
  assign pop_data  = empty ? {WIDTH{1'b0}} : mem[rd_ptr_r];

  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign ovf_set_s = push & full & ~pop_ok_s;

  // Storage array: written on accepted pushes, never reset.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: block RAM with aliased word addressing, plus an
// MMIO page holding a console transmit FIFO, its STATUS register and a
// free-running cycle counter. Load data returns one edge after the address.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]           ram [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] ram_idx_s;
  logic [31:0]           ram_rd_r;
  sel_e                  sel_s;
  sel_e                  sel_r;
  logic                  ram_we_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  clr_ovf_s;
  logic [31:0]           status_s;
  logic [31:0]           mmio_rd_s;
  logic [31:0]           mmio_q_r;
  logic [31:0]           cycles_r;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_ovf;
  logic [CW-1:0]         fifo_count;

  assign sel_s     = decode_addr(bus.address_dmem);
  assign ram_idx_s = bus.address_dmem[ADDR_WIDTH-1:0];
  assign ram_we_s  = bus.wren & (sel_s == SEL_RAM);
  assign push_s    = bus.wren & (sel_s == SEL_TXDATA);
  assign clr_ovf_s = bus.wren & (sel_s == SEL_STATUS) & bus.data[STAT_OVF_BIT];
  assign pop_s     = bus.tx_valid & bus.tx_ready;
  assign bus.tx_valid = ~fifo_empty;
  assign status_s  = pack_status(fifo_full, fifo_empty, fifo_ovf, 8'(fifo_count));

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_s),
    .push_data (bus.data),
    .pop       (pop_s),
    .clr_ovf   (clr_ovf_s),
    .pop_data  (bus.tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (fifo_ovf)
  );

  // Block RAM: synchronous read returns pre-write contents on a collision.
  always_ff @(posedge clock) begin
    if (ram_we_s) begin
      ram[ram_idx_s] <= bus.data;
    end
    ram_rd_r <= ram[ram_idx_s];
  end

  // MMIO read mux, sampled from pre-edge FIFO/counter state.
  always_comb begin
    mmio_rd_s = 32'h0000_0000;
    case (sel_s)
      SEL_STATUS: mmio_rd_s = status_s;
      SEL_CYCLES: mmio_rd_s = cycles_r;
      default:    mmio_rd_s = 32'h0000_0000;
    endcase
  end

  // Registered read select, MMIO read data and the free-running counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel_r    <= SEL_UNMAPPED;
      mmio_q_r <= 32'h0000_0000;
      cycles_r <= 32'h0000_0000;
    end else begin
      sel_r    <= sel_s;
      mmio_q_r <= mmio_rd_s;
      cycles_r <= cycles_r + 32'h0000_0001;
    end
  end

  // RAM data cannot be reset, so reset parks the select on the MMIO path.
  assign bus.q_dmem = (sel_r == SEL_RAM) ? ram_rd_r : mmio_q_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a driver updates a behavioural model
// and queues expected responses; a monitor compares them as the DUT produces.
module tb_dmem_responder;

  localparam int AW    = 12;
  localparam int DEPTH = 8;
  localparam logic [31:0] A_TX   = 32'hFFFF_0000;
  localparam logic [31:0] A_STAT = 32'hFFFF_0004;
  localparam logic [31:0] A_CYC  = 32'hFFFF_0008;
  localparam logic [31:0] A_IDLE = 32'hFFFF_0010;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  int unsigned edge_cnt = 0;
  int          passed = 0;
  int          total  = 0;

  dmem_responder_if bus();

  dmem_responder #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // Reference model
  logic [31:0] ram_m [int unsigned];
  logic [31:0] fifo_m[$];
  bit          ovf_m;
  logic [31:0] cyc_m;
  logic [31:0] tx_exp[$];

  typedef struct {
    int unsigned due;
    bit          chk;
    logic [31:0] val;
    string       name;
  } rd_t;
  rd_t rd_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] status_m();
    logic [31:0] s;
    s = 32'(fifo_m.size()) << 8;
    if (ovf_m) s = s + 32'd4;
    if (fifo_m.size() == 0) s = s + 32'd2;
    if (fifo_m.size() == DEPTH) s = s + 32'd1;
    return s;
  endfunction

  // Apply one cycle of stimulus (called just after a falling edge).
  task automatic drive(input logic [31:0] addr, input logic [31:0] dat,
                       input logic we, input logic rdy);
    rd_t         e;
    bit          mmio;
    logic [15:0] off;
    int unsigned key;
    bus.address_dmem = addr;
    bus.data         = dat;
    bus.wren         = we;
    bus.tx_ready     = rdy;
    check("tx_valid", {31'b0, bus.tx_valid}, (fifo_m.size() != 0) ? 32'd1 : 32'd0);
    mmio = (addr[31:16] == 16'hFFFF);
    off  = addr[15:0];
    key  = addr % (32'd1 << AW);
    e.due = edge_cnt + 1;
    e.chk = 1'b1;
    e.val = 32'h0;
    if (!mmio) begin
      e.name = "rd_ram";
      if (ram_m.exists(key)) e.val = ram_m[key];
      else e.chk = 1'b0;
    end else if (off == 16'h0004) begin
      e.name = "rd_status";
      e.val  = status_m();
    end else if (off == 16'h0008) begin
      e.name = "rd_cycles";
      e.val  = cyc_m;
    end else if (off == 16'h0000) begin
      e.name = "rd_txdata";
    end else begin
      e.name = "rd_unmapped";
    end
    rd_q.push_back(e);
    if (rdy && fifo_m.size() != 0) void'(fifo_m.pop_front());
    if (we) begin
      if (!mmio) ram_m[key] = dat;
      else if (off == 16'h0000) begin
        if (fifo_m.size() < DEPTH) begin
          fifo_m.push_back(dat);
          tx_exp.push_back(dat);
        end else begin
          ovf_m = 1'b1;
        end
      end else if (off == 16'h0004 && dat[2]) begin
        ovf_m = 1'b0;
      end
    end
    cyc_m = cyc_m + 32'd1;
  endtask

  task automatic cycle(input logic [31:0] addr, input logic [31:0] dat,
                       input logic we, input logic rdy);
    @(negedge clock);
    #1;
    drive(addr, dat, we, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(A_IDLE, 32'h0, 1'b0, rdy);
  endtask

  task automatic release_reset();
    @(negedge clock);
    #1;
    reset = 1'b1;
    drive(A_IDLE, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic assert_reset_mid();
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("rst_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
    check("rst_q_dmem", bus.q_dmem, 32'h0);
    check("rst_tx_data", bus.tx_data, 32'h0);
    fifo_m.delete();
    tx_exp.delete();
    rd_q.delete();
    ovf_m = 1'b0;
    cyc_m = 32'h0;
    repeat (2) @(negedge clock);
    check("rst_hold_q_dmem", bus.q_dmem, 32'h0);
  endtask

  // Monitor: compares load data and drained console words against the queues.
  initial begin
    rd_t e;
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        if (rd_q.size() != 0 && rd_q[0].due == edge_cnt) begin
          e = rd_q.pop_front();
          if (e.chk) check(e.name, bus.q_dmem, e.val);
        end
        if (bus.tx_valid) begin
          if (tx_exp.size() == 0) begin
            total++;
            $display("FAIL tx_unexpected: got 0x%08h, expected no word queued", bus.tx_data);
          end else begin
            check("tx_data", bus.tx_data, tx_exp[0]);
            if (bus.tx_ready) void'(tx_exp.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic        rdy;
    bus.address_dmem = A_IDLE;
    bus.data         = 32'h0;
    bus.wren         = 1'b0;
    bus.tx_ready     = 1'b0;
    ovf_m = 1'b0;
    cyc_m = 32'h0;

    #22;
    check("reset_q_dmem", bus.q_dmem, 32'h0);
    check("reset_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
    check("reset_tx_data", bus.tx_data, 32'h0);
    release_reset();
    cycle(A_CYC, 32'h0, 1'b0, 1'b0);
    cycle(A_STAT, 32'h0, 1'b0, 1'b0);

    // RAM store/load, aliasing and read-during-write
    cycle(32'h0000_0005, 32'hDEAD_BEEF, 1'b1, 1'b0);
    cycle(32'h0000_0005, 32'h0, 1'b0, 1'b0);
    cycle(32'h0000_1005, 32'h0, 1'b0, 1'b0);
    cycle(32'h0000_0005, 32'h1234_5678, 1'b1, 1'b0);
    cycle(32'h00AB_3005, 32'h0, 1'b0, 1'b0);
    cycle(A_TX, 32'h0, 1'b0, 1'b0);

    // Fill past capacity, drain in order
    for (int i = 1; i <= 9; i++) cycle(A_TX, 32'(i), 1'b1, 1'b0);
    cycle(A_STAT, 32'h0, 1'b0, 1'b0);
    idle(10, 1'b1);
    cycle(A_STAT, 32'h0, 1'b0, 1'b0);
    cycle(A_STAT, 32'hFFFF_FFFB, 1'b1, 1'b0);
    cycle(A_STAT, 32'h0, 1'b0, 1'b0);
    cycle(A_STAT, 32'h0000_0004, 1'b1, 1'b0);
    cycle(A_STAT, 32'h0, 1'b0, 1'b0);

    // Push into full FIFO with a simultaneous pop
    for (int i = 0; i < DEPTH; i++) cycle(A_TX, 32'h100 + 32'(i), 1'b1, 1'b0);
    cycle(A_TX, 32'h0000_00A5, 1'b1, 1'b1);
    cycle(A_STAT, 32'h0, 1'b0, 1'b0);
    idle(12, 1'b1);
    cycle(A_STAT, 32'h0, 1'b0, 1'b0);

    // Cycle counter spacing, ignored write, wrap
    cycle(A_CYC, 32'h0, 1'b0, 1'b0);
    idle(9, 1'b0);
    cycle(A_CYC, 32'h0, 1'b0, 1'b0);
    cycle(A_CYC, 32'h5555_5555, 1'b1, 1'b0);
    cycle(A_CYC, 32'h0, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    force dut.cycles_r = 32'hFFFF_FFFE;
    release dut.cycles_r;
    cyc_m = 32'hFFFF_FFFE;
    drive(A_CYC, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(A_CYC, 32'h0, 1'b0, 1'b0);

    // Unmapped MMIO
    cycle(32'hFFFF_000C, 32'hFFFF_FFFF, 1'b1, 1'b0);
    cycle(32'hFFFF_0001, 32'h0, 1'b0, 1'b0);
    cycle(A_STAT, 32'h0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      k   = $urandom_range(0, 9);
      d   = $urandom();
      rdy = ($urandom_range(0, 3) < (i / 150));
      we  = 1'b0;
      a   = {16'($urandom_range(0, 65534)), 4'($urandom()), 8'h00, 4'($urandom())};
      case (k)
        0, 1: we = 1'b1;
        2:    we = 1'b0;
        3, 4: begin a = A_TX; we = 1'b1; end
        5:    a = A_STAT;
        6:    begin a = A_STAT; we = 1'b1; end
        7:    begin a = A_CYC; we = 1'($urandom()); end
        8:    begin a = {16'hFFFF, 16'($urandom_range(9, 65535))}; we = 1'($urandom()); end
        default: a = A_IDLE;
      endcase
      cycle(a, d, we, rdy);
    end
    idle(12, 1'b1);

    // Reset with words queued
    for (int i = 0; i < 3; i++) cycle(A_TX, 32'h300 + 32'(i), 1'b1, 1'b0);
    cycle(A_STAT, 32'h0, 1'b0, 1'b0);
    assert_reset_mid();
    release_reset();
    cycle(A_STAT, 32'h0, 1'b0, 1'b0);
    cycle(A_CYC, 32'h0, 1'b0, 1'b0);
    cycle(32'h0000_0005, 32'h0, 1'b0, 1'b0);

    idle(10, 1'b1);
    @(negedge clock);
    #3;
    check("rd_q_drained", 32'(rd_q.size()), 32'h0);
    check("tx_q_drained", 32'(tx_exp.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
